serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder. It wraps one full-adder slice with a carry flip-flop and
//  operand/result shift registers, so wide operands are added one bit per clock.
//  It sits upstream of the result consumer and downstream of the operand source.
//  A start/busy/done handshake paces each operation.
// PARAMETERS
//  WIDTH  4  operand and sum width in bits; WIDTH >= 1
// PORTS
//  clk    in   1      single clock; all state changes on rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A; captured on the accepted start edge
//  b      in   WIDTH  operand B; captured on the accepted start edge
//  cin    in   1      carry-in; captured on the accepted start edge
//  busy   out  1      high while an operation is in progress (RUN)
//  done   out  1      one-cycle pulse; sum/cout are valid from this cycle on
//  sum    out  WIDTH  registered result; holds until the next completion or reset
//  cout   out  1      registered carry-out of the MSB; holds like sum
// BEHAVIOUR
//  Reset (async, any time): state=IDLE; busy, done, sum and cout = 0.
//   - Shift registers, carry FF and bit counter are also cleared.
//   - Reset mid-operation aborts it: no done pulse, sum/cout read 0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: if start=1 at an edge:
//   - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
//   - Otherwise the block stays in IDLE.
//  RUN: busy=1. Each edge:
//   - s = a_sh[0]^b_sh[0]^carry.
//   - carry <= majority(a_sh[0], b_sh[0], carry).
//   - a_sh, b_sh shift right by one; res_sh <= {s, res_sh[WIDTH-1:1]}, LSB first.
//   - cnt <= cnt+1.
//   - On the edge where cnt==WIDTH-1: sum <= {s, res_sh[WIDTH-1:1]}, cout <= carry-out.
//   - Same edge: state<=DONE. RUN lasts exactly WIDTH cycles.
//  DONE: done=1, busy=0 for exactly one cycle, then state<=IDLE on the next edge.
//  Latency: start is sampled at edge E0.
//   - busy is high after E0 through edge E_WIDTH.
//   - done is high in the cycle after edge E_WIDTH.
//   - Throughput: one operation per WIDTH+2 cycles. start held high re-triggers
//     when the block returns to IDLE.
//  Ignored inputs:
//   - start in RUN or DONE is ignored; no queueing.
//   - Changes on a, b or cin after the accepted edge have no effect on the result.
//  Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), for the captured values.
//  WIDTH=1: RUN lasts one cycle; done is high in the second cycle after start.
//  Counter width: $clog2(WIDTH)+1 bits, wide enough that it never wraps during RUN.
// TESTING
//  1. rst=1 mid-sim, no clock -> busy=0, done=0, sum=0, cout=0 immediately.
//  2. WIDTH=4, start with a=4'b0101, b=4'b0011, cin=0
//     -> busy for 4 cycles, then a 1-cycle done; sum=4'b1000, cout=0.
//  3. a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1.
//     a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
//  4. All 512 combinations of a, b, cin -> {cout,sum}==a+b+cin each time.
//     Exactly one done pulse per start.
//  5. start pulsed and a/b changed during RUN and DONE -> no extra done.
//     Result matches the originally captured operands.
//  6. rst asserted on RUN cycle 2, then released
//     -> no done, sum=0, busy=0; a new start (a=3, b=4, cin=1) gives sum=8, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from a single full-adder slice.
// Operands are captured on an accepted start, then added LSB first, one bit per
// clock, with the carry held in a flip-flop between bits.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start            request, sampled only while idle
//   a, b, cin        operands and carry-in, captured on the accepted start edge
//   busy             high while bits are being added
//   done             one-cycle pulse when sum/cout are updated
//   sum, cout        registered result, held until the next completion or reset
module serial_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit so the counter never wraps during an operation.
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             carry_next;
    logic             s_c;
    logic [CNT_W-1:0] cnt;
    logic             last_c;

    assign last_c = (cnt == CNT_W'(WIDTH - 1));

    // Full-adder slice and the result shift-in (MSB receives the new bit).
    always_comb begin
        s_c        = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_next   = WIDTH'({s_c, res_sh} >> 1);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_next;
                    res_sh <= res_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_c) begin
                        sum  <= res_next;
                        cout <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition of the captured operands.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return (WIDTH + 1)'(t);
    endfunction

    // Runs one operation starting just after a rising edge with the DUT idle.
    // With scramble set, start and the operands are churned during RUN and DONE.
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input bit scramble, input string tag);
        logic [WIDTH:0] exp;
        exp   = ref_add(xa, xb, xc);
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
            if (scramble) begin
                start = 1'b1;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                cin   = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " result"}, 32'({cout, sum}), 32'(exp));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_once"}, 32'(done), 32'd0);
        if (scramble) begin
            @(posedge clk); #1;
            check({tag, " no_retrigger"}, 32'({busy, done}), 32'd0);
            check({tag, " result_held"}, 32'({cout, sum}), 32'(exp));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({busy, done, cout, sum}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op(4'b0101, 4'b0011, 1'b0, 1'b0, "d_5p3");
        run_op(4'hF, 4'h1, 1'b0, 1'b0, "d_Fp1");
        run_op(4'hF, 4'hF, 1'b1, 1'b0, "d_FpFc");

        // Exhaustive operand sweep.
        for (int i = 0; i < 512; i++) begin
            run_op(WIDTH'(i), WIDTH'(i >> 4), 1'(i >> 8), 1'b0, "sweep");
        end

        // Random operands with start/operand churn during RUN and DONE.
        for (int i = 0; i < 20; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, "scramble");
        end

        // Leave a nonzero result, then reset asynchronously on RUN cycle 2.
        run_op(4'hF, 4'hF, 1'b1, 1'b0, "pre_reset");
        a     = 4'h7;
        b     = 4'h6;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_reset", 32'({busy, done, cout, sum}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < int'(WIDTH) + 2; k++) begin
            @(posedge clk); #1;
            check("after_abort", 32'({busy, done, cout, sum}), 32'd0);
        end
        run_op(4'd3, 4'd4, 1'b1, 1'b0, "post_reset");
        check("post_reset_sum", 32'(sum), 32'd8);
        check("post_reset_cout", 32'(cout), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
